// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between two byte requesters,
// plus the programmable baud divisor and the shared baud enable strobe.
//
// state       | meaning
// S_IDLE      | waiting for tbr=1 and a valid request; grant issued here
// S_LOAD      | tx_load pulse with the granted byte on tx_data
// S_WAIT_LOW  | waiting for the transmitter to drop tbr (load taken)
// S_WAIT_HIGH | waiting for tbr to return high (byte finished)
module uart_tx_scheduler #(
   parameter int               DIV_W       = 16,
   parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(325)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [7:0]       req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [7:0]       req1_data,
   output logic             req1_ready,
   input  logic             div_we,
   input  logic [DIV_W-1:0] div_wdata,
   input  logic             tbr,
   output logic             tx_load,
   output logic [7:0]       tx_data,
   output logic             baud_en,
   output logic             grant_id,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_LOW, S_WAIT_HIGH} state_t;

   state_t           state, state_nxt;
   logic             grant_any;
   logic             pick1;
   logic             enter_idle;
   logic [DIV_W-1:0] divisor;
   logic [DIV_W-1:0] baud_cnt;
   logic [DIV_W-1:0] pend_div;
   logic             pend_valid;

   assign grant_any  = (state == S_IDLE) && tbr && (req0_valid || req1_valid);
   // With both valid, the requester that did not own the last transfer wins.
   assign pick1      = req1_valid && (!req0_valid || (grant_id == 1'b0));
   assign enter_idle = (state == S_WAIT_HIGH) && tbr;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (grant_any) state_nxt = S_LOAD;
         S_LOAD:      state_nxt = S_WAIT_LOW;
         S_WAIT_LOW:  if (!tbr) state_nxt = S_WAIT_HIGH;
         S_WAIT_HIGH: if (tbr) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      tx_load    = 1'b0;
      busy       = 1'b1;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (!reset && grant_any) begin
               req1_ready = pick1;
               req0_ready = !pick1;
            end
         end
         S_LOAD:  tx_load = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_data  <= 8'h00;
         grant_id <= 1'b1;
      end else if (grant_any) begin
         tx_data  <= pick1 ? req1_data : req0_data;
         grant_id <= pick1;
      end
   end

   // Divisor changes always restart the count and suppress that cycle's strobe;
   // writes while busy are deferred until the FSM returns to IDLE.
   always_ff @(posedge clk) begin
      if (reset) begin
         divisor    <= DEFAULT_DIV;
         baud_cnt   <= '0;
         baud_en    <= 1'b0;
         pend_div   <= '0;
         pend_valid <= 1'b0;
      end else if (div_we && (state == S_IDLE)) begin
         divisor    <= div_wdata;
         baud_cnt   <= '0;
         baud_en    <= 1'b0;
         pend_valid <= 1'b0;
      end else if (enter_idle && (pend_valid || div_we)) begin
         divisor    <= div_we ? div_wdata : pend_div;
         baud_cnt   <= '0;
         baud_en    <= 1'b0;
         pend_valid <= 1'b0;
      end else begin
         if (div_we) begin
            pend_div   <= div_wdata;
            pend_valid <= 1'b1;
         end
         if (baud_cnt >= divisor) begin
            baud_cnt <= '0;
            baud_en  <= 1'b1;
         end else begin
            baud_cnt <= baud_cnt + DIV_W'(1);
            baud_en  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus pushes expected transfers
// and baud strobe cycles; a monitor pops and compares as the DUT presents them.
module tb_uart_tx_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [7:0]  req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        div_we;
   logic [15:0] div_wdata;
   logic        tbr;
   logic        tx_load;
   logic [7:0]  tx_data;
   logic        baud_en;
   logic        grant_id;
   logic        busy;

   typedef struct {
      logic       gid;
      logic [7:0] data;
   } exp_t;

   exp_t txq[$];
   int   bq[$];
   bit   baud_chk = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   passed = 0;

   uart_tx_scheduler #(.DIV_W(16), .DEFAULT_DIV(16'd325)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .div_we(div_we), .div_wdata(div_wdata), .tbr(tbr),
      .tx_load(tx_load), .tx_data(tx_data), .baud_en(baud_en),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
   endtask

   task automatic baud_close();
      baud_chk = 1'b0;
      chk("baud_missing", bq.size(), 0);
      bq.delete();
   endtask

   // Called at the negedge of a grant cycle; returns at the negedge of the next IDLE cycle.
   task automatic serve(input int n_low);
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      tbr = 1'b0;
      repeat (n_low) @(negedge clk);
      tbr = 1'b1;
      chk("busy_before_idle", busy, 1);
      @(negedge clk);
      chk("busy_after_idle", busy, 0);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (!reset && (req0_ready || req1_ready)) begin
            chk("one_ready", req0_ready & req1_ready, 0);
            chk("ready_busy", busy, 0);
            if (txq.size() == 0) chk("unexpected_ready", txq.size(), 1);
            else chk("ready_idx", req1_ready, txq[0].gid);
         end
         if (tx_load) begin
            if (txq.size() == 0) chk("unexpected_load", txq.size(), 1);
            else begin
               exp_t e;
               e = txq.pop_front();
               chk("tx_data", tx_data, e.data);
               chk("tx_grant", grant_id, e.gid);
               chk("tx_busy", busy, 1);
            end
         end
         if (baud_chk && baud_en) begin
            if (bq.size() == 0) chk("unexpected_baud", bq.size(), 1);
            else chk("baud_cycle", cyc, bq.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int t0, w;
      reset = 1'b1; tbr = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_data = 8'h00; req1_data = 8'h00;
      div_we = 1'b0; div_wdata = 16'd0;

      // reset then idle
      repeat (2) @(negedge clk);
      chk("rst_req0_ready", req0_ready, 0);
      chk("rst_req1_ready", req1_ready, 0);
      chk("rst_tx_load", tx_load, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_baud_en", baud_en, 0);
      chk("rst_grant_id", grant_id, 1);
      chk("rst_busy", busy, 0);
      reset = 1'b0;
      t0 = cyc;
      bq.push_back(t0 + 326);
      bq.push_back(t0 + 652);
      baud_chk = 1'b1;
      repeat (653) @(negedge clk);
      baud_close();

      // round robin: grants 0,1,0,1
      txq.push_back('{1'b0, 8'h11});
      txq.push_back('{1'b1, 8'h22});
      txq.push_back('{1'b0, 8'h11});
      txq.push_back('{1'b1, 8'h22});
      req0_data = 8'h11; req1_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         req0_valid = 1'b1;
         req1_valid = 1'b1;
         serve(3);
      end

      // single request, tbr low at t+2, high at t+20, idle at t+21
      txq.push_back('{1'b0, 8'hA5});
      req0_data = 8'hA5;
      req0_valid = 1'b1;
      serve(18);

      // divisor writes while idle: 3, then 0
      w = cyc;
      div_we = 1'b1; div_wdata = 16'd3;
      @(negedge clk);
      div_we = 1'b0;
      for (int k = 5; k <= 17; k += 4) bq.push_back(w + k);
      baud_chk = 1'b1;
      repeat (17) @(negedge clk);
      baud_close();
      w = cyc;
      div_we = 1'b1; div_wdata = 16'd0;
      @(negedge clk);
      div_we = 1'b0;
      for (int k = 2; k <= 9; k++) bq.push_back(w + k);
      baud_chk = 1'b1;
      repeat (9) @(negedge clk);
      baud_close();

      // write 3 together with a grant (applies at once), then 7 and 9 while busy
      w = cyc;
      txq.push_back('{1'b1, 8'h5C});
      bq.push_back(w + 5);
      bq.push_back(w + 9);
      bq.push_back(w + 23);
      bq.push_back(w + 33);
      div_we = 1'b1; div_wdata = 16'd3;
      req1_data = 8'h5C; req1_valid = 1'b1;
      for (int k = 1; k <= 34; k++) begin
         @(negedge clk);
         case (k)
            1:  begin div_we = 1'b0; req1_valid = 1'b0; baud_chk = 1'b1; end
            2:  begin tbr = 1'b0; div_we = 1'b1; div_wdata = 16'd7; end
            3:  div_we = 1'b0;
            5:  begin div_we = 1'b1; div_wdata = 16'd9; end
            6:  div_we = 1'b0;
            12: begin chk("busy_wait_high", busy, 1); tbr = 1'b1; end
            13: chk("busy_back_idle", busy, 0);
            34: baud_close();
            default: ;
         endcase
      end

      // reset in WAIT_LOW with req1 still requesting
      txq.push_back('{1'b1, 8'h77});
      req1_data = 8'h77; req1_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      tbr = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", busy, 0);
      chk("midrst_tx_load", tx_load, 0);
      chk("midrst_grant_id", grant_id, 1);
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_req1_ready", req1_ready, 0);
      reset = 1'b0;
      req1_valid = 1'b0;
      t0 = cyc;
      bq.push_back(t0 + 326);
      baud_chk = 1'b1;
      repeat (327) @(negedge clk);
      baud_close();

      chk("txq_empty", txq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
